mlp_driver: RTL and testbench
=============================

Name: mlp_driver

Overview:
- Initiator/host side of the MLP `init`/`ready`/`input_block`/`output_block` interface.
- Accepts input vectors from an upstream valid/ready stream and launches one MLP operation per vector.
- Waits for MLP completion, captures `output_block` into a small result FIFO, and presents results downstream on a valid/ready stream.
- Sits between the transformer token sequencer and the MLP block; detects hung MLP operations with a timeout.

Parameters:
- DATA_W, 8, width of `input_block`/`output_block` and of both stream data buses.
- FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2.
- TIMEOUT_CYC, 255, maximum cycles from `mlp_init` pulse to completion before abort; >= 2.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  reset, asynchronous, active-high.
- s_valid  in  1  upstream vector valid.
- s_ready  out  1  upstream vector accept.
- s_data  in  DATA_W  upstream vector.
- mlp_init  out  1  single-cycle start pulse to MLP.
- mlp_ready  in  1  MLP idle/result-valid indication.
- mlp_input_block  out  DATA_W  operand to MLP, registered.
- mlp_output_block  in  DATA_W  MLP result; valid while `mlp_ready`=1 after an operation.
- m_valid  out  1  result available.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_W  FIFO head result.
- err_clr  in  1  clears `err_timeout`.
- err_timeout  out  1  sticky: an MLP operation timed out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: s_ready=0, mlp_init=0, mlp_input_block=0, m_valid=0, m_data=0, err_timeout=0, busy=0. FSM goes to IDLE, FIFO empties, timeout counter clears.
- Reset mid-operation: in-flight MLP result is discarded. After reset, no launch occurs until `mlp_ready`=1.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- `s_ready` = (state==IDLE) && `mlp_ready` && FIFO not full. It is combinational from registered state, FIFO count and `mlp_ready`.
- IDLE: on `s_valid` && `s_ready`, latch `s_data` into `mlp_input_block` and go to LAUNCH.
- LAUNCH: `mlp_init`=1 for exactly this cycle, counter cleared; go to WAIT_BUSY. `mlp_input_block` is held until return to IDLE.
- WAIT_BUSY: wait for `mlp_ready`=0, then go to WAIT_DONE.
- WAIT_DONE: on `mlp_ready`=1, push `mlp_output_block` into FIFO and go to IDLE.
- Timeout: counter increments each cycle in WAIT_BUSY/WAIT_DONE. When it reaches TIMEOUT_CYC without completion:
  - set `err_timeout`;
  - go to IDLE;
  - no FIFO push.
- `err_timeout` priority: set has priority over `err_clr` in the same cycle; otherwise `err_clr`=1 clears it.
- Latency: accept at cycle T → `mlp_init` at T+1. If the MLP drops `ready` at T+2 and raises it at T+k, the FIFO push is at T+k, `m_valid` is high at T+k+1, and the next accept is possible at T+k+1.
- FIFO count width is clog2(FIFO_DEPTH+1); read/write pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle: count unchanged.
  - Pop when empty: not possible (`m_valid`=0).
  - Push when full: never occurs, because no launch is allowed when full.
- `m_valid` = count != 0; `m_data` = head entry, stable while `m_valid` && !`m_ready`.
- Throughput: at most one operation in flight; `s_data` is never accepted while `busy`.

Decomposition:
- Shared package `mlp_pkg`: DATA_W default constant, FSM state enum typedef (IDLE/LAUNCH/WAIT_BUSY/WAIT_DONE), TIMEOUT_CYC default.
- Sub-module `mlp_result_fifo`: synchronous FIFO with parameters DATA_W and FIFO_DEPTH and ports push/push_data/pop/head/count/full/empty. Same clock and reset.
- FSM and timeout counter stay in `mlp_driver`.

Test Plan:
- Single op: s_data=8'h3C, MLP model drops ready 1 cycle after init, result 8'hA5 after 5 cycles → exactly one `mlp_init` pulse with `mlp_input_block`=8'h3C; `m_valid` with `m_data`=8'hA5; `busy` low afterwards.
- Back-pressure: `m_ready`=0, 5 vectors offered, FIFO_DEPTH=4 → 4 results stored, `s_ready`=0 on the 5th. Raising `m_ready` drains in order, then the 5th is accepted.
- Simultaneous push/pop: FIFO count=2, push coincides with `m_ready`=1 → count stays 2, order preserved.
- Timeout: MLP never raises ready, TIMEOUT_CYC=16 → `err_timeout`=1 at cycle 16 after init, no `m_valid`, FSM in IDLE. `err_clr` clears it; a following good op completes normally.
- Reset mid-op: assert `reset` in WAIT_DONE with 2 results queued → all outputs 0 asynchronously, FIFO empty. Result arriving after reset release is ignored.
- Stalled MLP at idle: `mlp_ready`=0 with `s_valid`=1 → `s_ready`=0, no `mlp_init` issued.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared constants and FSM state type for the MLP host-side driver.
package mlp_pkg;

    localparam int unsigned MLP_DATA_W      = 8;
    localparam int unsigned MLP_TIMEOUT_CYC = 255;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } mlp_state_e;

endpackage

// File: rtl/mlp_result_fifo.sv
// Small synchronous result FIFO; head is the oldest entry, count tracks occupancy.
module mlp_result_fifo
    import mlp_pkg::*;
#(
    parameter int unsigned DATA_W     = MLP_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is reset too so the downstream data bus reads zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mlp_driver.sv
// Host side of the MLP init/ready handshake: launches one operation per
// accepted vector, queues results, and flags operations that never finish.
module mlp_driver
    import mlp_pkg::*;
#(
    parameter int unsigned DATA_W      = MLP_DATA_W,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = MLP_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              mlp_init,
    input  logic              mlp_ready,
    output logic [DATA_W-1:0] mlp_input_block,
    input  logic [DATA_W-1:0] mlp_output_block,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    input  logic              err_clr,
    output logic              err_timeout,
    output logic              busy
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    mlp_state_e        state_q, state_d;
    logic [DATA_W-1:0] in_blk_q, in_blk_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              err_set;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              accept;
    logic              tmo_hit;

    assign s_ready         = (state_q == IDLE) && mlp_ready && !fifo_full && !reset;
    assign accept          = s_valid && s_ready;
    // Fires on the TIMEOUT_CYC-th cycle spent waiting after the init pulse.
    assign tmo_hit         = (tmo_q == TW'(TIMEOUT_CYC - 1));
    assign busy            = (state_q != IDLE);
    assign mlp_input_block = in_blk_q;
    assign err_timeout     = err_q;
    assign m_valid         = (fifo_count != '0);

    always_comb begin
        state_d  = state_q;
        in_blk_d = in_blk_q;
        tmo_d    = tmo_q;
        mlp_init = 1'b0;
        push     = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    in_blk_d = s_data;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                mlp_init = 1'b1;
                tmo_d    = '0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_hit) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end else if (!mlp_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                tmo_d = tmo_q + 1'b1;
                if (mlp_ready) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    err_set = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            in_blk_q <= '0;
            tmo_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_blk_q <= in_blk_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
        end
    end

    mlp_result_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (mlp_output_block),
        .pop       (m_ready && !fifo_empty),
        .head      (m_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_mlp_driver.sv
// Directed bench for mlp_driver with a cycle-counting MLP model.
module tb_mlp_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       mlp_init;
    logic       mlp_ready;
    logic [7:0] mlp_input_block;
    logic [7:0] mlp_output_block;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       err_clr;
    logic       err_timeout;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int init_cnt = 0;

    // MLP model: drops ready the cycle after init, raises it done_cyc cycles after init.
    // done_cyc == 0 models a hung MLP; result = input ^ mdl_xor.
    logic       mdl_rdy = 1'b1;
    logic       mdl_act = 1'b0;
    int         mdl_cnt = 0;
    logic [7:0] mdl_out = 8'h00;
    int         done_cyc = 5;
    logic [7:0] mdl_xor = 8'h99;
    logic       stall = 1'b0;

    assign mlp_ready        = mdl_rdy & ~stall;
    assign mlp_output_block = mdl_out;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mlp_init) begin
            mdl_act <= 1'b1;
            mdl_cnt <= 1;
            mdl_rdy <= 1'b0;
            mdl_out <= ~(mlp_input_block ^ mdl_xor);
        end else if (mdl_act) begin
            if (done_cyc != 0 && mdl_cnt + 1 >= done_cyc) begin
                mdl_rdy <= 1'b1;
                mdl_out <= mlp_input_block ^ mdl_xor;
                mdl_act <= 1'b0;
            end
            mdl_cnt <= mdl_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (mlp_init && !reset) init_cnt <= init_cnt + 1;
    end

    mlp_driver #(
        .DATA_W      (8),
        .FIFO_DEPTH  (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .mlp_init         (mlp_init),
        .mlp_ready        (mlp_ready),
        .mlp_input_block  (mlp_input_block),
        .mlp_output_block (mlp_output_block),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .err_clr          (err_clr),
        .err_timeout      (err_timeout),
        .busy             (busy)
    );

    task automatic send(input logic [7:0] d);
        bit ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int n = 0; n < 60; n++) begin
            if (s_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1 s_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_accept data=%h accepted=%0b required=1", d, ok);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle busy=%0b required=0", busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_ready, mlp_init, m_valid, err_timeout, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b required=00000",
                     {s_ready, mlp_init, m_valid, err_timeout, busy});
        end
        checks++;
        if ({mlp_input_block, m_data} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_data got=%h required=0000", {mlp_input_block, m_data});
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_s_ready got=%0b required=1", s_ready);
        end
    endtask

    task automatic test_single_op();
        int i0, lat;
        mdl_xor = 8'h99; done_cyc = 5; m_ready = 1'b0;
        i0 = init_cnt;
        send(8'h3C);
        @(negedge clk);
        checks++;
        if ({mlp_init, mlp_input_block} !== {1'b1, 8'h3C}) begin
            failures++;
            $display("FAIL single_launch init/blk=%b/%h required=1/3c", mlp_init, mlp_input_block);
        end
        lat = 0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (m_valid && lat == 0) lat = j;
        end
        checks++;
        if (lat != 6) begin
            failures++;
            $display("FAIL single_latency cycles_after_init=%0d required=6", lat);
        end
        checks++;
        if ({m_valid, m_data, busy} !== {1'b1, 8'hA5, 1'b0}) begin
            failures++;
            $display("FAIL single_result valid/data/busy=%b/%h/%b required=1/a5/0", m_valid, m_data, busy);
        end
        checks++;
        if (init_cnt - i0 != 1) begin
            failures++;
            $display("FAIL single_init_pulses got=%0d required=1", init_cnt - i0);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pop m_valid=%0b required=0", m_valid);
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] din [5];
        int i0, seen_ready;
        din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'h33; din[3] = 8'h44; din[4] = 8'h55;
        m_ready = 1'b0; done_cyc = 3;
        for (int k = 0; k < 4; k++) begin
            send(din[k]);
            wait_idle(40);
        end
        i0 = init_cnt; seen_ready = 0;
        s_valid = 1'b1; s_data = din[4];
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (s_ready) seen_ready++;
        end
        s_valid = 1'b0;
        checks++;
        if (seen_ready != 0 || init_cnt != i0 || m_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_full s_ready_cycles=%0d inits=%0d m_valid=%0b required=0/0/1",
                     seen_ready, init_cnt - i0, m_valid);
        end
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({m_valid, m_data} !== {1'b1, din[k] ^ 8'h99}) begin
                failures++;
                $display("FAIL bp_drain%0d valid/data=%b/%h required=1/%h", k, m_valid, m_data, din[k] ^ 8'h99);
            end
            @(negedge clk);
        end
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty m_valid=%0b required=0", m_valid);
        end
        send(din[4]);
        wait_idle(40);
        checks++;
        if ({m_valid, m_data} !== {1'b1, 8'h55 ^ 8'h99}) begin
            failures++;
            $display("FAIL bp_fifth valid/data=%b/%h required=1/%h", m_valid, m_data, 8'h55 ^ 8'h99);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_simul_push_pop();
        m_ready = 1'b0; done_cyc = 5;
        send(8'h01); wait_idle(40);
        send(8'h02); wait_idle(40);
        send(8'h03);
        @(negedge clk);
        repeat (5) @(negedge clk);
        checks++;
        if ({m_valid, m_data, busy} !== {1'b1, 8'h01 ^ 8'h99, 1'b1}) begin
            failures++;
            $display("FAIL spp_before valid/data/busy=%b/%h/%b required=1/%h/1", m_valid, m_data, busy, 8'h01 ^ 8'h99);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        checks++;
        if ({m_valid, m_data, busy} !== {1'b1, 8'h02 ^ 8'h99, 1'b0}) begin
            failures++;
            $display("FAIL spp_after valid/data/busy=%b/%h/%b required=1/%h/0", m_valid, m_data, busy, 8'h02 ^ 8'h99);
        end
        m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_valid, m_data} !== {1'b1, 8'h03 ^ 8'h99}) begin
            failures++;
            $display("FAIL spp_order valid/data=%b/%h required=1/%h", m_valid, m_data, 8'h03 ^ 8'h99);
        end
        @(negedge clk);
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0) begin
            failures++;
            $display("FAIL spp_count m_valid=%0b required=0", m_valid);
        end
    endtask

    task automatic test_timeout();
        m_ready = 1'b0; done_cyc = 0;
        send(8'h5E);
        @(negedge clk);
        repeat (16) @(negedge clk);
        checks++;
        if ({err_timeout, busy} !== 2'b01) begin
            failures++;
            $display("FAIL tmo_before err/busy=%b/%b required=0/1", err_timeout, busy);
        end
        @(negedge clk);
        checks++;
        if ({err_timeout, busy, m_valid} !== 3'b100) begin
            failures++;
            $display("FAIL tmo_fire err/busy/m_valid=%b/%b/%b required=1/0/0", err_timeout, busy, m_valid);
        end
        done_cyc = 5;
        repeat (3) @(negedge clk);
        checks++;
        if ({err_timeout, m_valid, s_ready} !== 3'b101) begin
            failures++;
            $display("FAIL tmo_sticky err/m_valid/s_ready=%b/%b/%b required=1/0/1", err_timeout, m_valid, s_ready);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (err_timeout !== 1'b0) begin
            failures++;
            $display("FAIL tmo_clear err=%0b required=0", err_timeout);
        end
        send(8'h77);
        wait_idle(40);
        checks++;
        if ({m_valid, m_data, err_timeout} !== {1'b1, 8'h77 ^ 8'h99, 1'b0}) begin
            failures++;
            $display("FAIL tmo_recover valid/data/err=%b/%h/%b required=1/%h/0", m_valid, m_data, err_timeout, 8'h77 ^ 8'h99);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int i0, seen_valid;
        m_ready = 1'b0; done_cyc = 3;
        send(8'h0A); wait_idle(40);
        send(8'h0B); wait_idle(40);
        done_cyc = 8;
        send(8'h0C);
        @(negedge clk);
        i0 = init_cnt + 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, m_valid, mlp_ready} !== 3'b110) begin
            failures++;
            $display("FAIL rst_pre busy/m_valid/mlp_ready=%b/%b/%b required=1/1/0", busy, m_valid, mlp_ready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({s_ready, mlp_init, m_valid, err_timeout, busy, mlp_input_block, m_data} !== 21'h0) begin
            failures++;
            $display("FAIL rst_async outputs=%h required=000000",
                     {s_ready, mlp_init, m_valid, err_timeout, busy, mlp_input_block, m_data});
        end
        @(negedge clk);
        reset = 1'b0;
        seen_valid = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (m_valid || busy) seen_valid++;
        end
        checks++;
        if (seen_valid != 0 || init_cnt != i0) begin
            failures++;
            $display("FAIL rst_late_result valid_or_busy_cycles=%0d extra_inits=%0d required=0/0",
                     seen_valid, init_cnt - i0);
        end
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_idle_ready s_ready=%0b required=1", s_ready);
        end
    endtask

    task automatic test_stall();
        int i0, seen_ready;
        m_ready = 1'b0; done_cyc = 4;
        stall = 1'b1;
        s_valid = 1'b1; s_data = 8'hEE;
        i0 = init_cnt; seen_ready = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (s_ready) seen_ready++;
        end
        s_valid = 1'b0;
        checks++;
        if (seen_ready != 0 || init_cnt != i0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold s_ready_cycles=%0d inits=%0d busy=%0b required=0/0/0",
                     seen_ready, init_cnt - i0, busy);
        end
        stall = 1'b0;
        @(negedge clk);
        send(8'hEE);
        wait_idle(40);
        checks++;
        if ({m_valid, m_data} !== {1'b1, 8'hEE ^ 8'h99}) begin
            failures++;
            $display("FAIL stall_release valid/data=%b/%h required=1/%h", m_valid, m_data, 8'hEE ^ 8'h99);
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_back_pressure();
        test_simul_push_pop();
        test_timeout();
        test_reset_mid_op();
        test_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim_time_exceeded required=finish");
        $fatal(1);
    end

endmodule
